// File: rtl/vnu_pipe_if.sv
// vnu_pipe_if: input/output handshake and data bundle for vnu_pipe.
// master drives input words and output-side ready; slave is the VNU itself.
interface vnu_pipe_if #(
  parameter int unsigned DV    = 4,
  parameter int unsigned W_C2V = 6,
  parameter int unsigned W_LLR = 9,
  parameter int unsigned W_V2C = 10
);
  logic                          i_valid;
  logic                          o_ready;
  logic                          i_init;
  logic [W_LLR-1:0]              i_LOVNU;
  logic [0:DV-1][W_C2V-1:0]      i_data;
  logic                          o_valid;
  logic                          i_ready;
  logic [W_V2C-1:0]              o_app;
  logic [0:DV-1][W_V2C-1:0]      o_data;
  logic                          o_hard;
  logic                          o_sat;

  modport master (
    output i_valid, i_init, i_LOVNU, i_data, i_ready,
    input  o_ready, o_valid, o_app, o_data, o_hard, o_sat
  );

  modport slave (
    input  i_valid, i_init, i_LOVNU, i_data, i_ready,
    output o_ready, o_valid, o_app, o_data, o_hard, o_sat
  );
endinterface

// File: rtl/vnu_pipe.sv
// vnu_pipe: two-stage pipelined LDPC variable-node unit.
// S1 registers the full-precision C2V terms and their sum with the LLR;
// S2 registers APP, extrinsic V2C messages (APP - C2V[k]) and hard decision.
// Optional feature macro: VNU_SAT_EN (symmetric saturation of outputs and
// o_sat flag); without it outputs wrap to W_V2C bits and o_sat is 0.
module vnu_pipe #(
  parameter int unsigned DV    = 4,
  parameter int unsigned W_C2V = 6,
  parameter int unsigned W_LLR = 9,
  parameter int unsigned W_V2C = 10
) (
  input logic       clk,
  input logic       rst,
  vnu_pipe_if.slave bus
);

  localparam int unsigned W_M = (W_LLR > W_C2V) ? W_LLR : W_C2V;
  localparam int unsigned W_S = W_M + $clog2(DV + 1);
  // Working width for narrowing: holds both any W_S value and the W_V2C limit.
  localparam int unsigned W_X = ((W_S > W_V2C) ? W_S : W_V2C) + 1;

  // Narrow a full-precision value to W_V2C bits; MSB of result is the clip flag.
  function automatic logic [W_V2C:0] narrow(input logic signed [W_S-1:0] v);
    logic signed [W_X-1:0] x;
`ifdef VNU_SAT_EN
    logic signed [W_X-1:0] lim;
    logic signed [W_X-1:0] nlim;
`endif
    x = {{(W_X-W_S){v[W_S-1]}}, v};
`ifdef VNU_SAT_EN
    lim  = {{(W_X-W_V2C+1){1'b0}}, {(W_V2C-1){1'b1}}};
    nlim = -lim;
    if (x > lim)  return {1'b1, lim[W_V2C-1:0]};
    if (x < nlim) return {1'b1, nlim[W_V2C-1:0]};
`endif
    return {1'b0, x[W_V2C-1:0]};
  endfunction

  logic                          adv1, adv2;

  logic                          s1_valid_q, s1_valid_d;
  logic signed [W_S-1:0]         sum_q, sum_d;
  logic signed [W_S-1:0]         c2v_q [DV];
  logic signed [W_S-1:0]         c2v_d [DV];

  logic                          s2_valid_q, s2_valid_d;
  logic [W_V2C-1:0]              app_q, app_d;
  logic [0:DV-1][W_V2C-1:0]      data_q, data_d;
  logic                          hard_q, hard_d;
  logic                          sat_q, sat_d;

  // Stage advance enables: a stage moves when its downstream slot frees up.
  always_comb begin
    adv2 = !s2_valid_q || bus.i_ready;
    adv1 = !s1_valid_q || adv2;
  end

  // S1 next state: sign-extend inputs, zero C2V on first iteration, sum.
  always_comb begin
    s1_valid_d = s1_valid_q;
    sum_d      = sum_q;
    c2v_d      = c2v_q;
    if (adv1) begin
      s1_valid_d = bus.i_valid;
      if (bus.i_valid) begin
        sum_d = {{(W_S-W_LLR){bus.i_LOVNU[W_LLR-1]}}, bus.i_LOVNU};
        for (int unsigned k = 0; k < DV; k++) begin
          c2v_d[k] = bus.i_init ? '0
                   : {{(W_S-W_C2V){bus.i_data[k][W_C2V-1]}}, bus.i_data[k]};
          sum_d    = sum_d + c2v_d[k];
        end
      end
    end
  end

  // S2 next state: extrinsic subtraction, narrowing and hard decision.
  always_comb begin : s2_next
    logic [W_V2C:0] r;
    r          = '0;
    s2_valid_d = s2_valid_q;
    app_d      = app_q;
    data_d     = data_q;
    hard_d     = hard_q;
    sat_d      = sat_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        r      = narrow(sum_q);
        app_d  = r[W_V2C-1:0];
        sat_d  = r[W_V2C];
        hard_d = sum_q[W_S-1];
        for (int unsigned k = 0; k < DV; k++) begin
          r         = narrow(sum_q - c2v_q[k]);
          data_d[k] = r[W_V2C-1:0];
          sat_d     = sat_d | r[W_V2C];
        end
      end
    end
  end

  // Pipeline registers with synchronous reset discarding in-flight words.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      sum_q      <= '0;
      for (int unsigned k = 0; k < DV; k++) c2v_q[k] <= '0;
      s2_valid_q <= 1'b0;
      app_q      <= '0;
      data_q     <= '0;
      hard_q     <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      sum_q      <= sum_d;
      for (int unsigned k = 0; k < DV; k++) c2v_q[k] <= c2v_d[k];
      s2_valid_q <= s2_valid_d;
      app_q      <= app_d;
      data_q     <= data_d;
      hard_q     <= hard_d;
      sat_q      <= sat_d;
    end
  end

  assign bus.o_ready = adv1;
  assign bus.o_valid = s2_valid_q;
  assign bus.o_app   = app_q;
  assign bus.o_data  = data_q;
  assign bus.o_hard  = hard_q;
  assign bus.o_sat   = sat_q;

endmodule

// File: doc/vnu_pipe.md
# vnu_pipe

Parametrised, pipelined successor to the combinational shuffled variable-node unit of the LDPC decoder. The block accepts one channel LLR and DV check-to-variable (C2V) messages per transfer. It returns the a-posteriori sum (APP), DV extrinsic variable-to-check (V2C) messages and a hard decision. It adds a two-stage registered pipeline with valid/ready flow control, a first-iteration mode, and optional output saturation.

## Interface
- DV, 4: variable-node degree (number of C2V inputs / V2C outputs), ≥2
- W_C2V, 6: C2V message width, two's complement
- W_LLR, 9: channel LLR width, two's complement
- W_V2C, 10: output width (APP and V2C), two's complement
- W_S (localparam): max(W_LLR, W_C2V) + $clog2(DV+1); internal full-precision sum width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  input transfer valid
- o_ready  out  1  block can accept input
- i_init  in  1  first iteration: C2V inputs treated as zero
- i_LOVNU  in  W_LLR  channel LLR
- i_data  in  [0:DV-1][W_C2V-1:0]  C2V messages
- o_valid  out  1  output transfer valid
- i_ready  in  1  downstream accepts output
- o_app  out  W_V2C  APP = LLR + ΣC2V
- o_data  out  [0:DV-1][W_V2C-1:0]  extrinsic V2C, o_data[k] = APP − C2V[k]
- o_hard  out  1  hard decision, 1 when full-precision APP < 0
- o_sat  out  1  any output of this word saturated (0 when VNU_SAT_EN undefined)

## Operation
- Input accepted on cycle where i_valid && o_ready.
- Stage 1 (S1) register: sign-extended LLR and C2V (C2V zeroed when i_init=1), full-precision sum in W_S bits.
- Stage 2 (S2) register: DV subtractions APP−C2V[k] in W_S bits, then conversion to W_V2C (see Configuration); o_hard from sign of W_S APP.
- No overflow is possible inside W_S; only the final narrowing can clip or wrap.
- Flow control per stage: adv2 = !s2_valid || i_ready; adv1 = !s1_valid || adv2; o_ready = adv1 (combinational from i_ready); o_valid = s2_valid.
- Output data stable while o_valid && !i_ready; no word dropped or duplicated; order preserved.
- Reset: s1_valid=s2_valid=0, o_valid=0, o_app=0, o_data all 0, o_hard=0, o_sat=0; o_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation discards both in-flight words; no output after reset until new input is accepted.

## Timing
- Latency: 2 cycles from the accepting edge to o_valid, with i_ready held high.
- Throughput: 1 word/cycle with i_ready=1.
- With i_ready=0: at most 2 words are buffered. o_ready falls in the cycle after the second word is accepted while S2 is held. Two full stages with i_ready=0 force o_ready=0.
- i_ready rising with both stages full: S2 drains, S1 moves to S2, and a new input is accepted in the same cycle.

## Configuration
- VNU_SAT_EN defined: each W_S result is clipped to the symmetric range ±(2^(W_V2C−1)−1). o_sat=1 for the word if o_app or any o_data[k] was clipped.
- VNU_SAT_EN undefined: W_S results are truncated to the low W_V2C bits (two's-complement wrap). o_sat is tied 0. o_hard always uses the full-precision sign.

## Test plan
- Defaults; LLR=100, C2V={10,−5,20,−3}, i_init=0 -> after 2 cycles o_app=122, o_data={112,127,102,125}, o_hard=0, o_sat=0.
- Same stimulus with i_init=1 -> o_app=100, o_data={100,100,100,100}, o_hard=0.
- LLR=−256, C2V all −32 -> o_app=−384, o_data all −352, o_hard=1.
- W_V2C=8, LLR=200, C2V all 10:
  - with VNU_SAT_EN -> o_app=127, o_data all 127, o_sat=1, o_hard=0.
  - without VNU_SAT_EN -> o_app=−16, o_data all −26, o_sat=0.
- Backpressure: 4 consecutive valid words while i_ready=0 for 4 cycles:
  - o_ready drops after 2 accepted words; o_data stays stable.
  - After i_ready=1, all 4 words emerge in order, with no gaps once streaming.
- rst asserted for 1 cycle with 2 words in flight -> o_valid=0 and all outputs 0 the next cycle; o_ready=1; the next accepted word appears 2 cycles later with correct values.
